// File: rtl/ld_vio_report.sv
// ld_vio_report
// Takes memory-order-violation reports from the load-store unit and keeps
// only the oldest violating load. When that load reaches the ActiveList
// head, it blocks the load's retirement and issues a one-cycle
// load-violation recovery broadcast.
//
// Ports:
//   clk              processor clock
//   reset            asynchronous, active-high reset
//   vioValid_i       per-port violation report valid
//   vioAlId_i        per-port ActiveList id of the violating load
//   vioPc_i          per-port PC of the violating load
//   headValid_i      ActiveList head entry is valid and completed
//   headAlId_i       ActiveList head index
//   flush_i          another recovery is flushing the pipeline
//   vioAtHead_o      (combinational) head is the pending violating load; hold retirement
//   recoverFlag_o    recovery broadcast pulse
//   loadViolation_o  marks the broadcast as a load violation
//   recoverPC_o      PC of the violating load; valid while recoverFlag_o is high
//   vioCount_o       saturating count of issued broadcasts

`ifndef SIZE_ACTIVELIST_LOG
`define SIZE_ACTIVELIST_LOG 7
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif

module ld_vio_report #(
  parameter int NPORT        = 2,
  parameter int AL_LOG       = `SIZE_ACTIVELIST_LOG,
  parameter int PC_W         = `SIZE_PC,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NPORT-1:0]             vioValid_i,
  input  logic [NPORT-1:0][AL_LOG-1:0] vioAlId_i,
  input  logic [NPORT-1:0][PC_W-1:0]   vioPc_i,
  input  logic                         headValid_i,
  input  logic [AL_LOG-1:0]            headAlId_i,
  input  logic                         flush_i,
  output logic                         vioAtHead_o,
  output logic                         recoverFlag_o,
  output logic                         loadViolation_o,
  output logic [PC_W-1:0]              recoverPC_o,
  output logic [15:0]                  vioCount_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] FIRE    = 2'd2;
  localparam logic [1:0] DRAIN   = 2'd3;

  logic [1:0]        state_r;
  logic [1:0]        stateNext_s;
  logic [AL_LOG-1:0] pendId_r;
  logic [AL_LOG-1:0] pendIdNext_s;
  logic [PC_W-1:0]   pendPc_r;
  logic [PC_W-1:0]   pendPcNext_s;
  logic [2:0]        drainCnt_r;
  logic [2:0]        drainCntNext_s;

  logic              recoverFlag_r;
  logic              loadViolation_r;
  logic [PC_W-1:0]   recoverPC_r;
  logic [15:0]       vioCount_r;
  logic [15:0]       vioCountNext_s;

  logic              winValid_s;
  logic [AL_LOG-1:0] winAge_s;
  logic [AL_LOG-1:0] winId_s;
  logic [PC_W-1:0]   winPc_s;
  logic [AL_LOG-1:0] pendAge_s;
  logic              vioAtHead_s;

  // Pick the oldest valid report this cycle; ages are distances from the head
  // modulo the ActiveList size, so id wrap-around orders correctly. Strict
  // compare keeps the lowest port on a tie.
  always_comb begin : winnerSelect
    logic [AL_LOG-1:0] portAge;
    winValid_s = 1'b0;
    winAge_s   = '0;
    winId_s    = '0;
    winPc_s    = '0;
    portAge    = '0;
    for (int p = 0; p < NPORT; p++) begin
      portAge = vioAlId_i[p] - headAlId_i;
      if (vioValid_i[p] && (!winValid_s || (portAge < winAge_s))) begin
        winValid_s = 1'b1;
        winAge_s   = portAge;
        winId_s    = vioAlId_i[p];
        winPc_s    = vioPc_i[p];
      end else begin
        winValid_s = winValid_s;
      end
    end
  end

  // Age of the retained load and the retirement-blocking head match.
  // A concurrent flush wins over the match.
  always_comb begin
    pendAge_s   = pendId_r - headAlId_i;
    vioAtHead_s = (state_r == PENDING) && headValid_i &&
                  (headAlId_i == pendId_r) && !flush_i;
  end

  // Next-state logic for the retained entry, the FSM and the drain counter.
  always_comb begin
    stateNext_s    = state_r;
    pendIdNext_s   = pendId_r;
    pendPcNext_s   = pendPc_r;
    drainCntNext_s = drainCnt_r;
    case (state_r)
      IDLE: begin
        if (winValid_s && !flush_i) begin
          stateNext_s  = PENDING;
          pendIdNext_s = winId_s;
          pendPcNext_s = winPc_s;
        end else begin
          stateNext_s  = IDLE;
        end
      end
      PENDING: begin
        if (flush_i) begin
          stateNext_s  = IDLE;
          pendIdNext_s = '0;
          pendPcNext_s = '0;
        end else if (vioAtHead_s) begin
          // The head is the oldest instruction, so no report can replace it now.
          stateNext_s  = FIRE;
        end else if (winValid_s && (winAge_s < pendAge_s)) begin
          pendIdNext_s = winId_s;
          pendPcNext_s = winPc_s;
        end else begin
          stateNext_s  = PENDING;
        end
      end
      FIRE: begin
        stateNext_s    = DRAIN;
        drainCntNext_s = 3'(DRAIN_CYCLES);
      end
      DRAIN: begin
        if (drainCnt_r <= 3'd1) begin
          stateNext_s    = IDLE;
          drainCntNext_s = 3'd0;
        end else begin
          drainCntNext_s = drainCnt_r - 3'd1;
        end
      end
      default: begin
        stateNext_s    = IDLE;
        drainCntNext_s = 3'd0;
      end
    endcase
  end

  // Saturating broadcast counter, bumped as the broadcast is launched.
  always_comb begin
    if (vioAtHead_s && (vioCount_r != 16'hFFFF)) begin
      vioCountNext_s = vioCount_r + 16'd1;
    end else begin
      vioCountNext_s = vioCount_r;
    end
  end

  // FSM and retained-entry registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      pendId_r   <= '0;
      pendPc_r   <= '0;
      drainCnt_r <= 3'd0;
    end else begin
      state_r    <= stateNext_s;
      pendId_r   <= pendIdNext_s;
      pendPc_r   <= pendPcNext_s;
      drainCnt_r <= drainCntNext_s;
    end
  end

  // Registered broadcast outputs: high exactly for the cycle spent in FIRE;
  // the PC holds its last broadcast value otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      recoverFlag_r   <= 1'b0;
      loadViolation_r <= 1'b0;
      recoverPC_r     <= '0;
      vioCount_r      <= 16'd0;
    end else begin
      recoverFlag_r   <= vioAtHead_s;
      loadViolation_r <= vioAtHead_s;
      recoverPC_r     <= vioAtHead_s ? pendPc_r : recoverPC_r;
      vioCount_r      <= vioCountNext_s;
    end
  end

  assign vioAtHead_o     = vioAtHead_s;
  assign recoverFlag_o   = recoverFlag_r;
  assign loadViolation_o = loadViolation_r;
  assign recoverPC_o     = recoverPC_r;
  assign vioCount_o      = vioCount_r;

endmodule

// File: tb/tb_ld_vio_report.sv
// Directed testbench for ld_vio_report with a broadcast-PC scoreboard.
module tb_ld_vio_report;

  logic             clk;
  logic             reset;
  logic [1:0]       vioValid;
  logic [1:0][6:0]  vioAlId;
  logic [1:0][31:0] vioPc;
  logic             headValid;
  logic [6:0]       headAlId;
  logic             flush;
  logic             vioAtHead;
  logic             recoverFlag;
  logic             loadViolation;
  logic [31:0]      recoverPC;
  logic [15:0]      vioCount;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] expQ[$];

  ld_vio_report #(.NPORT(2), .AL_LOG(7), .PC_W(32), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .vioValid_i(vioValid), .vioAlId_i(vioAlId), .vioPc_i(vioPc),
    .headValid_i(headValid), .headAlId_i(headAlId), .flush_i(flush),
    .vioAtHead_o(vioAtHead), .recoverFlag_o(recoverFlag),
    .loadViolation_o(loadViolation), .recoverPC_o(recoverPC),
    .vioCount_o(vioCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v0, input logic [6:0] id0, input logic [31:0] pc0,
                     input logic v1, input logic [6:0] id1, input logic [31:0] pc1,
                     input logic hv, input logic [6:0] hd, input logic fl);
    vioValid   = {v1, v0};
    vioAlId[0] = id0;
    vioPc[0]   = pc0;
    vioAlId[1] = id1;
    vioPc[1]   = pc1;
    headValid  = hv;
    headAlId   = hd;
    flush      = fl;
  endtask

  task automatic idle();
    drv(1'b0, 7'd0, 32'd0, 1'b0, 7'd0, 32'd0, 1'b0, 7'd0, 1'b0);
  endtask

  task automatic report1(input logic [6:0] hd, input logic [6:0] id, input logic [31:0] pc);
    drv(1'b1, id, pc, 1'b0, 7'd0, 32'd0, 1'b0, hd, 1'b0);
    #1;
    check("noHeadMatchOnReport", {31'd0, vioAtHead}, 32'd0);
    step();
  endtask

  task automatic headNoMatch(input logic [6:0] hd, input string tag);
    drv(1'b0, 7'd0, 32'd0, 1'b0, 7'd0, 32'd0, 1'b1, hd, 1'b0);
    #1;
    check(tag, {31'd0, vioAtHead}, 32'd0);
    step();
  endtask

  // Head reaches the pending load: expect vioAtHead now, a one-cycle broadcast
  // next cycle, then walk through the drain back to IDLE.
  task automatic fire(input logic [6:0] hd, input logic [31:0] pc, input logic [15:0] cnt);
    drv(1'b0, 7'd0, 32'd0, 1'b0, 7'd0, 32'd0, 1'b1, hd, 1'b0);
    #1;
    check("vioAtHead", {31'd0, vioAtHead}, 32'd1);
    expQ.push_back(pc);
    step();
    check("recoverFlagFire", {31'd0, recoverFlag}, 32'd1);
    idle();
    step();
    check("recoverFlagAfter", {31'd0, recoverFlag}, 32'd0);
    check("loadViolationAfter", {31'd0, loadViolation}, 32'd0);
    check("recoverPCHold", recoverPC, pc);
    check("vioCount", {16'd0, vioCount}, {16'd0, cnt});
    step();
    step();
  endtask

  // Scoreboard side: every broadcast seen mid-cycle must match the oldest
  // outstanding expected PC.
  always @(negedge clk) begin
    if (!reset && recoverFlag) begin
      vectors++;
      assert (expQ.size() > 0) else begin
        errors++;
        $error("FAIL unexpectedBroadcast observed=%h expected=none", recoverPC);
      end
      if (expQ.size() > 0) begin
        check("scoreboardPC", recoverPC, expQ.pop_front());
        check("scoreboardLoadViolation", {31'd0, loadViolation}, 32'd1);
      end
    end
  end

  initial begin
    reset = 1'b1;
    idle();
    step();
    step();
    check("resetRecoverFlag", {31'd0, recoverFlag}, 32'd0);
    check("resetLoadViolation", {31'd0, loadViolation}, 32'd0);
    check("resetRecoverPC", recoverPC, 32'd0);
    check("resetVioCount", {16'd0, vioCount}, 32'd0);
    check("resetVioAtHead", {31'd0, vioAtHead}, 32'd0);
    reset = 1'b0;

    // Single report
    report1(7'd5, 7'd9, 32'h0000_1040);
    fire(7'd9, 32'h0000_1040, 16'd1);

    // Oldest selection: id15 beats id20, id12 replaces, id14 does not
    drv(1'b1, 7'd20, 32'h0000_2000, 1'b1, 7'd15, 32'h0000_1500, 1'b0, 7'd10, 1'b0);
    step();
    report1(7'd10, 7'd12, 32'h0000_1200);
    report1(7'd10, 7'd14, 32'h0000_1400);
    headNoMatch(7'd15, "oldestNot15");
    headNoMatch(7'd14, "oldestNot14");
    fire(7'd12, 32'h0000_1200, 16'd2);

    // Equal age on both ports: port 0 wins
    drv(1'b1, 7'd70, 32'h0000_7000, 1'b1, 7'd70, 32'h0000_7001, 1'b0, 7'd68, 1'b0);
    step();
    fire(7'd70, 32'h0000_7000, 16'd3);

    // Wrap-around: head 120, id3 (age 11) replaced by id125 (age 5)
    report1(7'd120, 7'd3, 32'h0000_0300);
    report1(7'd120, 7'd125, 32'h0000_1250);
    headNoMatch(7'd3, "wrapNot3");
    fire(7'd125, 32'h0000_1250, 16'd4);

    // Flush while pending, coinciding with a head match and a report
    report1(7'd28, 7'd30, 32'h0000_3000);
    drv(1'b1, 7'd31, 32'h0000_3100, 1'b0, 7'd0, 32'd0, 1'b1, 7'd30, 1'b1);
    #1;
    check("flushBeatsHeadMatch", {31'd0, vioAtHead}, 32'd0);
    step();
    headNoMatch(7'd30, "flushedNot30");
    headNoMatch(7'd31, "flushedNot31");
    // Flush in IDLE drops the report
    drv(1'b1, 7'd40, 32'h0000_4000, 1'b0, 7'd0, 32'd0, 1'b0, 7'd38, 1'b1);
    step();
    headNoMatch(7'd40, "flushIdleNot40");
    check("noBroadcastAfterFlush", {31'd0, recoverFlag}, 32'd0);
    check("countAfterFlush", {16'd0, vioCount}, 32'd4);

    // Drain: report at head match, in FIRE and in both drain cycles are ignored
    report1(7'd48, 7'd50, 32'h0000_5000);
    drv(1'b1, 7'd51, 32'h0000_5100, 1'b0, 7'd0, 32'd0, 1'b1, 7'd50, 1'b0);
    #1;
    check("drainHeadMatch", {31'd0, vioAtHead}, 32'd1);
    expQ.push_back(32'h0000_5000);
    step();
    check("drainFireFlag", {31'd0, recoverFlag}, 32'd1);
    drv(1'b1, 7'd60, 32'h0000_6000, 1'b0, 7'd0, 32'd0, 1'b0, 7'd48, 1'b0);
    step();
    drv(1'b1, 7'd61, 32'h0000_6100, 1'b0, 7'd0, 32'd0, 1'b0, 7'd48, 1'b0);
    step();
    drv(1'b1, 7'd62, 32'h0000_6200, 1'b0, 7'd0, 32'd0, 1'b0, 7'd48, 1'b0);
    step();
    report1(7'd48, 7'd63, 32'h0000_6300);
    headNoMatch(7'd60, "drainNot60");
    headNoMatch(7'd61, "drainNot61");
    headNoMatch(7'd62, "drainNot62");
    headNoMatch(7'd51, "drainNot51");
    fire(7'd63, 32'h0000_6300, 16'd6);

    // Asynchronous reset during FIRE
    report1(7'd78, 7'd80, 32'h0000_8000);
    drv(1'b0, 7'd0, 32'd0, 1'b0, 7'd0, 32'd0, 1'b1, 7'd80, 1'b0);
    #1;
    check("rstHeadMatch", {31'd0, vioAtHead}, 32'd1);
    step();
    check("rstFireFlag", {31'd0, recoverFlag}, 32'd1);
    check("rstFirePC", recoverPC, 32'h0000_8000);
    #1;
    reset = 1'b1;
    #1;
    check("midFireRecoverFlag", {31'd0, recoverFlag}, 32'd0);
    check("midFireLoadViolation", {31'd0, loadViolation}, 32'd0);
    check("midFireRecoverPC", recoverPC, 32'd0);
    check("midFireVioCount", {16'd0, vioCount}, 32'd0);
    check("midFireVioAtHead", {31'd0, vioAtHead}, 32'd0);
    step();
    reset = 1'b0;
    headNoMatch(7'd80, "postResetNot80");
    check("postResetFlag", {31'd0, recoverFlag}, 32'd0);

    // Saturation: preload the counter one short of the limit
    idle();
    force dut.vioCount_r = 16'hFFFE;
    step();
    release dut.vioCount_r;
    #1;
    check("satPreload", {16'd0, vioCount}, 32'h0000_FFFE);
    report1(7'd1, 7'd5, 32'h0000_A000);
    fire(7'd5, 32'h0000_A000, 16'hFFFF);
    report1(7'd5, 7'd7, 32'h0000_B000);
    fire(7'd7, 32'h0000_B000, 16'hFFFF);

    step();
    check("scoreboardEmpty", expQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ld_vio_report.md
Name: ld_vio_report

Overview:
- Sits between the load-store unit and the ActiveList commit stage, and produces the load-violation recovery broadcast.
- Collects memory-order-violation reports from the LSU and retains only the oldest violating load. Any younger report is squashed by that load's recovery, so it need not be kept.
- When the retained load reaches the ActiveList head, it blocks that load's retirement and issues a one-cycle recovery broadcast: recoverFlag, loadViolation and the load PC. The dispatch-stage load-violation predictor and the pipeline flush logic consume this broadcast.

Parameters:
- NPORT, 2, number of violation report ports from the LSU per cycle.
- AL_LOG, `SIZE_ACTIVELIST_LOG, ActiveList index width.
- PC_W, `SIZE_PC, PC width.
- DRAIN_CYCLES, 2, cycles reports are ignored after a broadcast; range 1..7.

Ports:
- clk  in  1  processor clock.
- reset  in  1  asynchronous, active-high reset.
- vioValid_i  in  NPORT  per-port violation report valid.
- vioAlId_i  in  NPORT x AL_LOG  ActiveList id of the violating load.
- vioPc_i  in  NPORT x PC_W  PC of the violating load.
- headValid_i  in  1  ActiveList head entry is valid and completed.
- headAlId_i  in  AL_LOG  ActiveList head index.
- flush_i  in  1  another recovery (older branch mispredict or exception) is flushing the pipeline.
- vioAtHead_o  out  1  combinational; the head instruction is the pending violating load and must not retire.
- recoverFlag_o  out  1  recovery broadcast pulse.
- loadViolation_o  out  1  marks the broadcast as a load violation.
- recoverPC_o  out  PC_W  PC of the violating load; valid while recoverFlag_o is high.
- vioCount_o  out  16  saturating count of issued broadcasts.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, pendId=0, pendPc=0, drain counter=0.
  - recoverFlag_o=0, loadViolation_o=0, recoverPC_o=0, vioCount_o=0, vioAtHead_o=0.
- Age rule: age(id) = (id - headAlId_i) mod 2^AL_LOG, unsigned, using the current cycle's head. A smaller age is older.
  - Among valid ports in the same cycle, the smallest age wins. On equal age, the lowest port index wins.
- IDLE:
  - If any report is valid and flush_i=0: capture the winning id and PC, then go to PENDING.
  - If flush_i=1: reports are dropped and the state stays IDLE.
- PENDING:
  - flush_i=1: go to IDLE and clear the pending entry. Reports in the same cycle are dropped. flush_i has priority over the head-match check below.
  - A winning report with age strictly less than age(pendId) replaces the pending entry. An equal or younger report is ignored.
  - vioAtHead_o = (state==PENDING) & headValid_i & (headAlId_i==pendId) & ~flush_i.
  - When vioAtHead_o=1, the next state is FIRE. Replacement cannot occur in that cycle, because nothing is older than the head.
- FIRE: exactly one cycle.
  - recoverFlag_o=1, loadViolation_o=1, recoverPC_o=pendPc. All three are registered outputs.
  - vioCount_o increments, saturating at 16'hFFFF.
  - Next state is DRAIN, with the drain counter loaded to DRAIN_CYCLES.
- DRAIN:
  - All reports and flush_i are ignored.
  - The counter decrements each cycle. When it reaches 0, the next state is IDLE.
- Outputs in all states other than FIRE: recoverFlag_o=0, loadViolation_o=0, recoverPC_o holds its last value.
- Latency: head match in cycle N produces the broadcast in cycle N+1. The earliest next capture is at cycle N+2+DRAIN_CYCLES.
- Boundary cases:
  - ActiveList id wrap (e.g. head=126, ids 127 and 1 with AL_LOG=7) is ordered correctly by the mod-age rule.
  - A report arriving in the same cycle as the head match is ignored.
  - Reset mid-FIRE or mid-DRAIN returns to IDLE immediately and clears vioCount_o.

Test Plan:
- Single report: head=5, port0 reports id=9, PC=0x1040. Advance the head to 9 with headValid=1 → vioAtHead_o=1 that cycle. Next cycle recoverFlag_o=loadViolation_o=1 and recoverPC_o=0x1040 for exactly one cycle, then vioCount_o=1.
- Oldest selection: head=10, port0 id=20 and port1 id=15 in the same cycle, then port0 id=12 one cycle later → the pending entry is id 12. A later report with id=14 does not replace it.
- Wrap-around (AL_LOG=7): head=120, pending id=3, then a new report with id=125 → the entry is replaced by 125 (age 5 < age 11). The broadcast fires when the head reaches 125.
- flush_i while PENDING: pending id=30, flush_i=1 with a report of id=31 in the same cycle → state is IDLE, no broadcast when the head later reaches 30 or 31, and vioAtHead_o stays 0.
- Drain: after a broadcast, reports on each of the next DRAIN_CYCLES(=2) cycles are ignored. A report on the third cycle after FIRE is captured.
- Asynchronous reset asserted during FIRE → all outputs are 0 within the same cycle and vioCount_o=0. Saturation: force 65535 broadcasts, then one more → vioCount_o stays 16'hFFFF.
